// File: rtl/alu_result_fifo.sv
// In-order result buffer for the ALU output: stores {error, data} pairs in a
// DEPTH-entry ring and tracks a sticky error flag and a running flag.
module alu_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // in_ready and out_valid come from registered state only.
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_error,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_error,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         running,
    output logic                         error_sticky
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH:0]  r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_sticky;
    logic            r_running;

    logic            w_push;
    logic            w_pop;
    logic [WIDTH:0]  w_head;

    always_comb begin
        in_ready  = (r_count != FULL_COUNT);
        out_valid = (r_count != '0);
        w_push    = in_valid && in_ready;
        w_pop     = out_valid && out_ready;
        w_head    = r_mem[r_rd_ptr];
    end

    // Head is masked so a stale slot never leaks out while the FIFO is empty.
    assign out_data     = out_valid ? w_head[WIDTH-1:0] : '0;
    assign out_error    = out_valid ? w_head[WIDTH] : 1'b0;
    assign count        = r_count;
    assign running      = r_running;
    assign error_sticky = r_sticky;

    always_ff @(posedge clock) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= {in_error, in_data};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_sticky  <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_running <= 1'b1;
            if (clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_sticky <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                    if (in_error) begin
                        r_sticky <= 1'b1;
                    end
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the FIFO contents.
module tb_alu_result_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_error = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  out_data;
    logic              out_error;
    logic [CW-1:0]     count;
    logic              running;
    logic              error_sticky;

    int total = 0;
    int bad   = 0;

    // Expected FIFO contents, head at index 0: {error, data}.
    logic [WIDTH:0] exp_q[$];
    logic           m_sticky  = 1'b0;
    logic           m_running = 1'b0;

    alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_error     (in_error),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_error    (out_error),
        .count        (count),
        .running      (running),
        .error_sticky (error_sticky)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic e,
                        input logic r, input logic c);
        in_valid  = v;
        in_data   = d;
        in_error  = e;
        out_ready = r;
        clear     = c;
        @(posedge clock);
        #1;
    endtask

    // Monitor: inputs change just after rising edges, so at the falling edge
    // they show what the next rising edge will act on.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            m_sticky  = 1'b0;
            m_running = 1'b0;
            chk("rst_count", 32'(count), 0);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_out_data", 32'(out_data), 0);
            chk("rst_out_error", 32'(out_error), 0);
            chk("rst_sticky", 32'(error_sticky), 0);
            chk("rst_running", 32'(running), 0);
        end else begin
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(exp_q[0][WIDTH-1:0]));
                chk("out_error", 32'(out_error), 32'(exp_q[0][WIDTH]));
            end else begin
                chk("out_data_idle", 32'(out_data), 0);
                chk("out_error_idle", 32'(out_error), 0);
            end
            chk("error_sticky", 32'(error_sticky), 32'(m_sticky));
            chk("running", 32'(running), 32'(m_running));

            // Advance the model to the state after the coming rising edge.
            m_running = 1'b1;
            if (clear) begin
                exp_q.delete();
                m_sticky = 1'b0;
            end else begin
                automatic bit can_push = in_valid && (exp_q.size() != DEPTH);
                automatic bit can_pop  = out_ready && (exp_q.size() != 0);
                if (can_pop) void'(exp_q.pop_front());
                if (can_push) begin
                    exp_q.push_back({in_error, in_data});
                    if (in_error) m_sticky = 1'b1;
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        step(0, '0, 0, 0, 0);

        // Three pushes held, then drained in order.
        step(1, 16'h1111, 0, 0, 0);
        step(1, 16'h2222, 0, 0, 0);
        step(1, 16'h3333, 0, 0, 0);
        chk("t1_count", 32'(count), 3);
        chk("t1_head", 32'(out_data), 32'h1111);
        chk("t1_running", 32'(running), 1);
        repeat (4) step(0, '0, 0, 1, 0);
        chk("t1_empty_data", 32'(out_data), 0);

        // Full FIFO refuses a push even while popping.
        for (int i = 0; i < DEPTH; i++) step(1, 16'(16'h4000 + i), 0, 0, 0);
        chk("t2_full_ready", 32'(in_ready), 0);
        step(1, 16'hBEEF, 0, 1, 0);
        chk("t2_count", 32'(count), 3);
        repeat (5) step(0, '0, 0, 1, 0);

        // Streaming across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            step(1, 16'(16'h5000 + i), 0, 1, 0);
            chk("t3_stream_count", 32'(count), 1);
        end
        repeat (2) step(0, '0, 0, 1, 0);

        // Errored entry followed by a clean one.
        step(1, 16'h00A5, 1, 0, 0);
        chk("t4_sticky", 32'(error_sticky), 1);
        step(1, 16'h0123, 0, 0, 0);
        chk("t4_head_err", 32'(out_error), 1);
        repeat (3) step(0, '0, 0, 1, 0);
        chk("t4_sticky_kept", 32'(error_sticky), 1);

        // Clear wins over simultaneous push and pop.
        step(1, 16'h0F0F, 1, 0, 0);
        step(1, 16'h0E0E, 0, 0, 0);
        step(1, 16'h5555, 0, 1, 1);
        chk("t5_count", 32'(count), 0);
        chk("t5_sticky", 32'(error_sticky), 0);
        chk("t5_running", 32'(running), 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end

        // Asynchronous reset between edges.
        step(0, '0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 16'(16'h7000 + i), 0, 0, 0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_count", 32'(count), 0);
        chk("t6_async_valid", 32'(out_valid), 0);
        chk("t6_async_running", 32'(running), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("t6_running_back", 32'(running), 1);
        repeat (3) step(0, '0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
